// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencer: RAW interlock via issue scoreboard (no forwarding), EX-branch squash, HLT drain/resume.
// Controls are combinational from state/scoreboard/ID inputs (zero latency); stalls hold PC and IF/ID and bubble ID/EX.
module pipeline_hazard_ctrl #(
    parameter int REG_ADR_W = 3,
    parameter int DEPTH     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_ADR_W-1:0] id_rs_adr,
    input  logic [REG_ADR_W-1:0] id_rt_adr,
    input  logic                 id_reads_rs,
    input  logic                 id_reads_rt,
    input  logic                 id_regwrite,
    input  logic [REG_ADR_W-1:0] id_wadr,
    input  logic                 id_is_halt,
    input  logic                 ex_branch_taken,
    input  logic                 start,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 halted,
    output logic [DEPTH-1:0]     sb_busy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DEPTH-1:0]       sb_v_q, sb_v_d;
    logic [REG_ADR_W-1:0]   sb_adr_q [DEPTH];
    logic [CNT_W-1:0]       stall_cnt_q;

    logic hit_rs, hit_rt, hazard, issue, cnt_inc;
    logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c, halted_c;

    // The WB entry still counts: the register file is written on the same edge it would be read after.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v_q[i] && (sb_adr_q[i] == id_rs_adr)) hit_rs = 1'b1;
            if (sb_v_q[i] && (sb_adr_q[i] == id_rt_adr)) hit_rt = 1'b1;
        end
        hazard = id_valid & ((id_reads_rs & hit_rs) | (id_reads_rt & hit_rt));
    end

    always_comb begin
        state_d       = state_q;
        issue         = 1'b0;
        cnt_inc       = 1'b0;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        halted_c      = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (id_valid && id_is_halt) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    state_d       = DRAIN;
                end else if (hazard) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    cnt_inc       = 1'b1;
                end else begin
                    issue = id_valid;
                end
            end
            DRAIN: begin
                pc_stall_c    = 1'b1;
                ifid_stall_c  = 1'b1;
                idex_bubble_c = 1'b1;
                if (sb_v_q == '0) state_d = HALTED;
            end
            HALTED: begin
                halted_c      = 1'b1;
                idex_bubble_c = 1'b1;
                if (start) begin
                    ifid_flush_c = 1'b1;
                    state_d      = RUN;
                end else begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign sb_v_d = {sb_v_q[DEPTH-2:0], issue & id_regwrite};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            sb_v_q      <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) sb_adr_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            sb_v_q      <= sb_v_d;
            sb_adr_q[0] <= id_wadr;
            for (int i = 1; i < DEPTH; i++) sb_adr_q[i] <= sb_adr_q[i-1];
            if (cnt_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign pc_stall    = pc_stall_c    & ~reset;
    assign ifid_stall  = ifid_stall_c  & ~reset;
    assign ifid_flush  = ifid_flush_c  & ~reset;
    assign idex_bubble = idex_bubble_c & ~reset;
    assign halted      = halted_c      & ~reset;
    assign sb_busy     = sb_v_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: literal vector table, hand-written reset/saturation sequences, random run vs. history model.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 3;
    localparam int D  = 3;
    localparam int CW = 16;

    localparam logic [4:0] C_NONE   = 5'b00000; // {pc_stall, ifid_stall, ifid_flush, idex_bubble, halted}
    localparam logic [4:0] C_STALL  = 5'b11010;
    localparam logic [4:0] C_BRANCH = 5'b00110;
    localparam logic [4:0] C_HALT   = 5'b11011;
    localparam logic [4:0] C_RESUME = 5'b00111;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_reads_rs, id_reads_rt, id_regwrite, id_is_halt, ex_branch_taken, start;
    logic [AW-1:0] id_rs_adr, id_rt_adr, id_wadr;
    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, halted;
    logic [D-1:0]  sb_busy;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADR_W(AW), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs_adr(id_rs_adr), .id_rt_adr(id_rt_adr),
        .id_reads_rs(id_reads_rs), .id_reads_rt(id_reads_rt),
        .id_regwrite(id_regwrite), .id_wadr(id_wadr), .id_is_halt(id_is_halt),
        .ex_branch_taken(ex_branch_taken), .start(start),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .halted(halted), .sb_busy(sb_busy), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] rs, rt;
        logic          rrs, rrt, rw;
        logic [AW-1:0] wa;
        logic          hlt, br, st;
        logic [4:0]    ctl;
        logic [D-1:0]  busy;
        logic [CW-1:0] cnt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(logic v, logic [AW-1:0] rs, logic [AW-1:0] rt, logic rrs, logic rrt,
                                logic rw, logic [AW-1:0] wa, logic hlt, logic br, logic st,
                                logic [4:0] ctl, logic [D-1:0] busy, logic [CW-1:0] cnt);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.rrs = rrs; t.rrt = rrt; t.rw = rw; t.wa = wa;
        t.hlt = hlt; t.br = br; t.st = st; t.ctl = ctl; t.busy = busy; t.cnt = cnt;
        return t;
    endfunction

    function automatic logic [23:0] got();
        return {pc_stall, ifid_stall, ifid_flush, idex_bubble, halted, sb_busy, stall_cnt};
    endfunction

    task automatic chk(input string nm, input logic [4:0] ctl, input logic [D-1:0] busy, input logic [CW-1:0] cnt);
        logic [23:0] g;
        g = got();
        total++;
        if (g !== {ctl, busy, cnt}) begin
            bad++;
            $display("FAIL %s: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                     nm, g[23:19], g[18:16], g[15:0], ctl, busy, cnt);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs_adr = t.rs; id_rt_adr = t.rt;
        id_reads_rs = t.rrs; id_reads_rt = t.rrt; id_regwrite = t.rw; id_wadr = t.wa;
        id_is_halt = t.hlt; ex_branch_taken = t.br; start = t.st;
    endtask

    task automatic step(input string nm, input vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        chk(nm, t.ctl, t.busy, t.cnt);
    endtask

    vec_t tbl[20];
    vec_t idle;

    // Reference model: issue history by cycle number, not a shift register.
    int          cyc;
    int          last_wr[8];
    bit          wr_at[int];
    int          mode;            // 0 run, 1 drain, 2 halted
    logic [CW-1:0] mcnt;

    function automatic bit recent(input logic [AW-1:0] a);
        return (cyc - last_wr[a]) <= D;
    endfunction

    initial begin
        idle = mk(0,0,0,0,0,0,0,0,0,0, C_NONE, 3'b000, 16'h0);

        tbl[0]  = mk(1,1,2,1,1,1,3,0,0,0, C_NONE,   3'b000, 16'd0);
        tbl[1]  = mk(1,3,0,1,0,1,4,0,0,0, C_STALL,  3'b001, 16'd0);
        tbl[2]  = mk(1,3,0,1,0,1,4,0,0,0, C_STALL,  3'b010, 16'd1);
        tbl[3]  = mk(1,3,0,1,0,1,4,0,0,0, C_STALL,  3'b100, 16'd2);
        tbl[4]  = mk(1,3,0,1,0,1,4,0,0,0, C_NONE,   3'b000, 16'd3);
        tbl[5]  = mk(1,2,0,1,0,1,1,0,0,0, C_NONE,   3'b001, 16'd3);
        tbl[6]  = mk(1,5,0,1,0,1,4,0,0,0, C_NONE,   3'b011, 16'd3);
        tbl[7]  = mk(0,0,0,0,0,0,0,0,0,0, C_NONE,   3'b111, 16'd3);
        tbl[8]  = mk(1,4,0,1,0,1,6,0,1,0, C_BRANCH, 3'b110, 16'd3);
        tbl[9]  = mk(0,0,0,0,0,0,0,0,0,0, C_NONE,   3'b100, 16'd3);
        tbl[10] = mk(0,0,0,0,0,0,0,0,0,0, C_NONE,   3'b000, 16'd3);
        tbl[11] = mk(1,0,0,0,0,1,1,0,0,0, C_NONE,   3'b000, 16'd3);
        tbl[12] = mk(1,0,0,0,0,1,2,0,0,0, C_NONE,   3'b001, 16'd3);
        tbl[13] = mk(0,0,0,0,0,0,0,0,0,0, C_NONE,   3'b011, 16'd3);
        tbl[14] = mk(1,0,0,0,0,0,0,1,0,0, C_STALL,  3'b110, 16'd3);
        tbl[15] = mk(0,0,0,0,0,0,0,0,0,1, C_STALL,  3'b100, 16'd3);
        tbl[16] = mk(0,0,0,0,0,0,0,0,0,0, C_STALL,  3'b000, 16'd3);
        tbl[17] = mk(0,0,0,0,0,0,0,0,1,0, C_HALT,   3'b000, 16'd3);
        tbl[18] = mk(0,0,0,0,0,0,0,0,0,1, C_RESUME, 3'b000, 16'd3);
        tbl[19] = mk(0,0,0,0,0,0,0,0,0,1, C_NONE,   3'b000, 16'd3);

        // Reset state, with inputs that would otherwise demand a halt stall.
        reset = 1'b1;
        drive(mk(1,0,0,0,0,0,0,1,0,0, C_NONE, 3'b000, 16'h0));
        #1;
        chk("reset_state", C_NONE, 3'b000, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(idle);

        for (int i = 0; i < 20; i++) step($sformatf("tbl%0d", i), tbl[i]);

        // Reset in the middle of DRAIN.
        step("rst_pre_wr",  mk(1,0,0,0,0,1,2,0,0,0, C_NONE,  3'b000, 16'd3));
        step("rst_pre_hlt", mk(1,0,0,0,0,0,0,1,0,0, C_STALL, 3'b001, 16'd3));
        step("rst_drain",   mk(0,0,0,0,0,0,0,0,0,0, C_STALL, 3'b010, 16'd3));
        @(negedge clk);
        reset = 1'b1;
        drive(mk(1,0,0,0,0,0,0,1,0,0, C_NONE, 3'b000, 16'h0));
        #1;
        chk("rst_assert", C_NONE, 3'b000, 16'h0);
        @(negedge clk);
        #1;
        chk("rst_hold", C_NONE, 3'b000, 16'h0);
        reset = 1'b0;
        drive(idle);
        #1;
        chk("rst_release", C_NONE, 3'b000, 16'h0);
        step("post_rst_run", mk(1,0,0,0,0,1,7,0,0,0, C_NONE,  3'b000, 16'd0));
        step("post_rst_hz0", mk(1,0,7,0,1,0,0,0,0,0, C_STALL, 3'b001, 16'd0));
        step("post_rst_hz1", mk(1,0,7,0,1,0,0,0,0,0, C_STALL, 3'b010, 16'd1));
        step("post_rst_hz2", mk(1,0,7,0,1,0,0,0,0,0, C_STALL, 3'b100, 16'd2));
        step("post_rst_iss", mk(1,0,7,0,1,0,0,0,0,0, C_NONE,  3'b000, 16'd3));

        // Counter saturation from a preloaded near-max value.
        @(negedge clk);
        drive(idle);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        step("sat_idle", mk(0,0,0,0,0,0,0,0,0,0, C_NONE,  3'b000, 16'hFFFE));
        step("sat_wr",   mk(1,0,0,0,0,1,5,0,0,0, C_NONE,  3'b000, 16'hFFFE));
        step("sat_hz0",  mk(1,5,0,1,0,1,5,0,0,0, C_STALL, 3'b001, 16'hFFFE));
        step("sat_hz1",  mk(1,5,0,1,0,1,5,0,0,0, C_STALL, 3'b010, 16'hFFFF));
        step("sat_hz2",  mk(1,5,0,1,0,1,5,0,0,0, C_STALL, 3'b100, 16'hFFFF));
        step("sat_iss",  mk(1,5,0,1,0,1,5,0,0,0, C_NONE,  3'b000, 16'hFFFF));
        step("sat_hz3",  mk(1,5,0,1,0,1,5,0,0,0, C_STALL, 3'b001, 16'hFFFF));
        step("sat_hz4",  mk(1,5,0,1,0,1,5,0,0,0, C_STALL, 3'b010, 16'hFFFF));
        step("sat_hz5",  mk(1,5,0,1,0,1,5,0,0,0, C_STALL, 3'b100, 16'hFFFF));

        // Randomized run against the history model.
        @(negedge clk);
        reset = 1'b1;
        drive(idle);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        mode = 0;
        mcnt = '0;
        for (int r = 0; r < 8; r++) last_wr[r] = -1000;
        wr_at.delete();

        for (int n = 0; n < 3000; n++) begin
            logic [D-1:0] ebusy;
            logic [4:0]   ectl;
            bit hz, iss, inc;
            int nxt;
            @(negedge clk);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs_adr       = AW'($urandom_range(0, 7));
            id_rt_adr       = AW'($urandom_range(0, 7));
            id_reads_rs     = $urandom_range(0, 1) == 1;
            id_reads_rt     = $urandom_range(0, 1) == 1;
            id_regwrite     = ($urandom_range(0, 3) != 0);
            id_wadr         = AW'($urandom_range(0, 7));
            id_is_halt      = ($urandom_range(0, 11) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            start           = ($urandom_range(0, 3) == 0);
            #1;
            for (int i = 0; i < D; i++) ebusy[i] = wr_at.exists(cyc - 1 - i);
            hz  = id_valid && ((id_reads_rs && recent(id_rs_adr)) || (id_reads_rt && recent(id_rt_adr)));
            iss = 1'b0;
            inc = 1'b0;
            nxt = mode;
            ectl = C_NONE;
            if (mode == 0) begin
                if (ex_branch_taken) ectl = C_BRANCH;
                else if (id_valid && id_is_halt) begin ectl = C_STALL; nxt = 1; end
                else if (hz) begin ectl = C_STALL; inc = 1'b1; end
                else iss = id_valid;
            end else if (mode == 1) begin
                ectl = C_STALL;
                if (ebusy == '0) nxt = 2;
            end else begin
                if (start) begin ectl = C_RESUME; nxt = 0; end
                else ectl = C_HALT;
            end
            chk($sformatf("rand%0d", n), ectl, ebusy, mcnt);
            @(posedge clk);
            if (iss && id_regwrite) begin
                last_wr[id_wadr] = cyc;
                wr_at[cyc] = 1'b1;
            end
            if (inc && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            mode = nxt;
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
